raifes_hasti_uart_tx: RTL and testbench



---
 rtl/raifes_hasti_uart_tx_if.sv | 37 +++
 rtl/raifes_hasti_uart_tx.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_raifes_hasti_uart_tx.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/raifes_hasti_uart_tx_if.sv
// ---------------------------------------------------------------------------
// raifes_hasti_uart_tx_if
//   HASTI (AHB-lite) peripheral bus bundle for the UART transmitter.
//   master modport: drives address/control/write data, receives response.
//   slave  modport: receives address/control/write data, drives response.
//   Signals:
//     hsel    slave select
//     haddr   address (the slave decodes haddr[3:2] only)
//     hwrite  1 = write transfer
//     htrans  transfer type, htrans[1]=1 means NONSEQ/SEQ
//     hsize   transfer size (ignored by the slave)
//     hwdata  write data, valid in the data phase
//     hrdata  read data, valid in the data phase
//     hready  transfer done (tied 1 by the slave)
//     hresp   response (tied 0 = OKAY by the slave)
// ---------------------------------------------------------------------------
interface raifes_hasti_uart_tx_if;
   logic        hsel;
   logic [31:0] haddr;
   logic        hwrite;
   logic [1:0]  htrans;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;

   modport master (
      output hsel, haddr, hwrite, htrans, hsize, hwdata,
      input  hrdata, hready, hresp
   );

   modport slave (
      input  hsel, haddr, hwrite, htrans, hsize, hwdata,
      output hrdata, hready, hresp
   );
endinterface

// File: rtl/raifes_hasti_uart_tx.sv
// ---------------------------------------------------------------------------
// raifes_hasti_uart_tx
//   Memory-mapped UART transmitter on the HASTI peripheral port. Bytes
//   written to DATA are queued in a FIFO and sent 8N1, LSB first, on tx.
//
//   Register map (word offsets, haddr[3:2]):
//     0x0 DATA     W: push hwdata[7:0]; reads 0
//     0x4 STATUS   R: {level[15:8], overflow[3], empty[2], full[1], busy[0]}
//                  W: writing 1 to bit3 clears overflow
//     0x8 BAUD_DIV R/W: 16-bit divider, bit period = BAUD_DIV+1 clocks
//     0xC CTRL     R/W: bit0 tx_en (reset 1), bit1 parity_en (see below)
//
//   Optional feature, macro RAIFES_UART_PARITY_EN:
//     defined   -> CTRL bit1 enables an even parity bit after the data bits
//     undefined -> CTRL bit1 reads 0, frames are always 10 bit periods
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high reset
//     bus    HASTI slave modport (zero wait states, always OKAY)
//     tx     registered serial output, idles high
// ---------------------------------------------------------------------------
module raifes_hasti_uart_tx #(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic                         clk,
   input  logic                         reset,
   raifes_hasti_uart_tx_if.slave        bus,
   output logic                         tx
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_BAUD   = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef RAIFES_UART_PARITY_EN
   localparam logic [2:0] ST_PARITY = 3'd4;
`endif

   // ------------------------------------------------------------------------
   // Bus address/data phase tracking
   // ------------------------------------------------------------------------
   logic       addr_accept;
   logic       data_phase;
   logic       write_q;
   logic [1:0] addr_q;

   assign bus.hready  = 1'b1;
   assign bus.hresp   = 1'b0;
   assign addr_accept = bus.hsel & bus.htrans[1] & bus.hready;

   // NOTE: clocked state is always assigned with <= so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_phase <= 1'b0;
         write_q    <= 1'b0;
         addr_q     <= 2'd0;
      end else begin
         data_phase <= addr_accept;
         if (addr_accept) begin
            addr_q  <= bus.haddr[3:2];
            write_q <= bus.hwrite;
         end
      end
   end

   // Writes commit on the edge that ends the data phase.
   logic wr_commit, wr_data, wr_status, wr_baud, wr_ctrl;
   assign wr_commit = data_phase & write_q;
   assign wr_data   = wr_commit & (addr_q == REG_DATA);
   assign wr_status = wr_commit & (addr_q == REG_STATUS);
   assign wr_baud   = wr_commit & (addr_q == REG_BAUD);
   assign wr_ctrl   = wr_commit & (addr_q == REG_CTRL);

   // ------------------------------------------------------------------------
   // Configuration registers
   // ------------------------------------------------------------------------
   logic [15:0] baud_div;
   logic        tx_en;
   logic        parity_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         baud_div <= DEFAULT_DIV;
         tx_en    <= 1'b1;
      end else begin
         if (wr_baud) baud_div <= bus.hwdata[15:0];
         if (wr_ctrl) tx_en    <= bus.hwdata[0];
      end
   end

`ifdef RAIFES_UART_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        parity_en <= 1'b0;
      else if (wr_ctrl) parity_en <= bus.hwdata[1];
   end
`else
   assign parity_en = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Transmit FIFO: extra pointer bit distinguishes full from empty
   // ------------------------------------------------------------------------
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wptr, rptr, level;
   logic          fifo_full, fifo_empty;
   logic          push_ok, pop;
   logic          overflow;
   logic [7:0]    fifo_rd;

   assign level      = wptr - rptr;
   assign fifo_full  = (level == PW'(FIFO_DEPTH));
   assign fifo_empty = (level == '0);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_ok    = wr_data & (~fifo_full | pop);
   assign fifo_rd    = fifo_mem[rptr[AW-1:0]];

   // NOTE: the storage array has no reset; the pointers alone define which
   // entries are valid, so clearing the data would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wptr[AW-1:0]] <= bus.hwdata[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr     <= '0;
         rptr     <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wptr <= wptr + PW'(1);
         if (pop)     rptr <= rptr + PW'(1);
         if (wr_data & ~push_ok)
            overflow <= 1'b1;
         else if (wr_status & bus.hwdata[3])
            overflow <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Serializer FSM and baud counter
   // ------------------------------------------------------------------------
   logic [2:0]  state;
   logic [15:0] baud_cnt;
   logic [15:0] bit_div;       // divider frozen for the bit in flight
   logic [15:0] baud_div_nxt;  // divider for the next bit, incl. a same-edge write
   logic [7:0]  shift;
   logic [2:0]  bit_idx;
   logic        tick;
   logic        can_start;
`ifdef RAIFES_UART_PARITY_EN
   logic        parity_q;
`endif

   assign baud_div_nxt = wr_baud ? bus.hwdata[15:0] : baud_div;
   assign tick         = (state != ST_IDLE) && (baud_cnt == bit_div);
   assign can_start    = tx_en & ~fifo_empty;
   assign pop          = can_start & ((state == ST_IDLE) | ((state == ST_STOP) & tick));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         baud_cnt <= 16'd0;
         bit_div  <= DEFAULT_DIV;
         shift    <= 8'd0;
         bit_idx  <= 3'd0;
         tx       <= 1'b1;
`ifdef RAIFES_UART_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else if (state == ST_IDLE) begin
         baud_cnt <= 16'd0;
         tx       <= 1'b1;
         if (pop) begin
            state   <= ST_START;
            shift   <= fifo_rd;
            bit_div <= baud_div_nxt;
            tx      <= 1'b0;
`ifdef RAIFES_UART_PARITY_EN
            parity_q <= ^fifo_rd;
`endif
         end
      end else if (!tick) begin
         baud_cnt <= baud_cnt + 16'd1;
      end else begin
         // Bit boundary: restart the count and pick up the current divider.
         baud_cnt <= 16'd0;
         bit_div  <= baud_div_nxt;
         case (state)
            ST_START: begin
               state   <= ST_DATA;
               bit_idx <= 3'd0;
               tx      <= shift[0];
            end
            ST_DATA: begin
               if (bit_idx == 3'd7) begin
`ifdef RAIFES_UART_PARITY_EN
                  if (parity_en) begin
                     state <= ST_PARITY;
                     tx    <= parity_q;
                  end else begin
                     state <= ST_STOP;
                     tx    <= 1'b1;
                  end
`else
                  state <= ST_STOP;
                  tx    <= 1'b1;
`endif
               end else begin
                  shift   <= {1'b0, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  tx      <= shift[1];
               end
            end
`ifdef RAIFES_UART_PARITY_EN
            ST_PARITY: begin
               state <= ST_STOP;
               tx    <= 1'b1;
            end
`endif
            ST_STOP: begin
               if (pop) begin
                  // Next byte already queued: start bit follows with no gap.
                  state <= ST_START;
                  shift <= fifo_rd;
                  tx    <= 1'b0;
`ifdef RAIFES_UART_PARITY_EN
                  parity_q <= ^fifo_rd;
`endif
               end else begin
                  state <= ST_IDLE;
                  tx    <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Read data mux
   // ------------------------------------------------------------------------
   logic [31:0] rdata;
   logic        busy;

   assign busy = (state != ST_IDLE);

   // NOTE: rdata gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      rdata = 32'd0;
      if (data_phase & ~write_q) begin
         case (addr_q)
            REG_STATUS: rdata = {16'd0, 8'(level), 4'd0, overflow, fifo_empty, fifo_full, busy};
            REG_BAUD:   rdata = {16'd0, baud_div};
            REG_CTRL:   rdata = {30'd0, parity_en, tx_en};
            default:    rdata = 32'd0;
         endcase
      end
   end

   assign bus.hrdata = rdata;

   // Bus bits this slave does not decode.
   logic unused_bus_bits;
   assign unused_bus_bits = ^{bus.hsize, bus.htrans[0], bus.haddr[31:4],
                              bus.haddr[1:0], bus.hwdata[31:16]};

endmodule

// File: tb/tb_raifes_hasti_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_raifes_hasti_uart_tx
//   Self-checking bench for raifes_hasti_uart_tx: a register-access vector
//   table plus directed sequences for framing, FIFO overflow, back-to-back
//   frames, mid-frame divider change, mid-frame reset and the optional
//   parity bit (RAIFES_UART_PARITY_EN).
// ---------------------------------------------------------------------------
module tb_raifes_hasti_uart_tx;

   localparam logic [3:0] A_DATA   = 4'h0;
   localparam logic [3:0] A_STATUS = 4'h4;
   localparam logic [3:0] A_BAUD   = 4'h8;
   localparam logic [3:0] A_CTRL   = 4'hC;
`ifdef RAIFES_UART_PARITY_EN
   localparam logic [31:0] CTRL_MASK = 32'h3;
`else
   localparam logic [31:0] CTRL_MASK = 32'h1;
`endif

   typedef struct packed {
      logic [3:0]  addr;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic tx;
   int   total = 0;
   int   bad   = 0;

   vec_t         vecs [14];
   logic [31:0]  rd;
   logic [511:0] wave;

   raifes_hasti_uart_tx_if bus ();

   raifes_hasti_uart_tx dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave),
      .tx    (tx)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // All bus tasks start and end on a falling edge.
   task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
      bus.hsel   = 1'b1;
      bus.htrans = 2'b10;
      bus.hwrite = 1'b1;
      bus.haddr  = {28'd0, addr};
      @(negedge clk);
      bus.hsel   = 1'b0;
      bus.htrans = 2'b00;
      bus.hwrite = 1'b0;
      bus.hwdata = data;
      @(negedge clk);
   endtask

   task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
      bus.hsel   = 1'b1;
      bus.htrans = 2'b10;
      bus.hwrite = 1'b0;
      bus.haddr  = {28'd0, addr};
      @(negedge clk);
      bus.hsel   = 1'b0;
      bus.htrans = 2'b00;
      data       = bus.hrdata;
   endtask

   task automatic read_check(input string name, input logic [3:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(addr, d);
      check(name, {480'd0, d}, {480'd0, exp});
   endtask

   // Samples tx on the next n falling edges; bit i = i-th sample.
   task automatic capture(input int n, output logic [511:0] w);
      w = '0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         w[i] = tx;
      end
   endtask

   // Expected line: bits[0] first; the first n_first bits last len_first
   // cycles each, the rest len_rest cycles each.
   function automatic logic [511:0] build_wave(input logic [10:0] bits, input int nbits,
                                               input int n_first, input int len_first,
                                               input int len_rest);
      logic [511:0] w;
      int pos;
      int len;
      w   = '0;
      pos = 0;
      for (int b = 0; b < nbits; b++) begin
         len = (b < n_first) ? len_first : len_rest;
         for (int k = 0; k < len; k++) begin
            w[pos] = bits[b];
            pos++;
         end
      end
      return w;
   endfunction

   initial begin
      // addr, wr, wdata, expected read value
      vecs[0]  = '{A_STATUS, 1'b0, 32'h0,         32'h0000_0004};
      vecs[1]  = '{A_BAUD,   1'b0, 32'h0,         32'd433};
      vecs[2]  = '{A_CTRL,   1'b0, 32'h0,         32'h1};
      vecs[3]  = '{A_DATA,   1'b0, 32'h0,         32'h0};
      vecs[4]  = '{A_BAUD,   1'b1, 32'hABCD_0005, 32'h0};
      vecs[5]  = '{A_BAUD,   1'b0, 32'h0,         32'h5};
      vecs[6]  = '{A_CTRL,   1'b1, 32'h0,         32'h0};
      vecs[7]  = '{A_CTRL,   1'b0, 32'h0,         32'h0};
      vecs[8]  = '{A_CTRL,   1'b1, 32'hFFFF_FFFF, 32'h0};
      vecs[9]  = '{A_CTRL,   1'b0, 32'h0,         CTRL_MASK};
      vecs[10] = '{A_CTRL,   1'b1, 32'h1,         32'h0};
      vecs[11] = '{A_STATUS, 1'b0, 32'h0,         32'h0000_0004};
      vecs[12] = '{A_BAUD,   1'b1, 32'h3,         32'h0};
      vecs[13] = '{A_BAUD,   1'b0, 32'h0,         32'h3};

      bus.hsel   = 1'b0;
      bus.haddr  = 32'd0;
      bus.hwrite = 1'b0;
      bus.htrans = 2'b00;
      bus.hsize  = 3'b010;
      bus.hwdata = 32'd0;

      // --- reset state ---
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("reset_tx%0d", i), {511'd0, tx}, 512'd1);
      end
      check("reset_hready", {511'd0, bus.hready}, 512'd1);
      check("reset_hresp",  {511'd0, bus.hresp},  512'd0);
      check("reset_hrdata", {480'd0, bus.hrdata}, 512'd0);
      reset = 1'b0;
      @(negedge clk);

      // --- register vector table ---
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].wr) begin
            bus_write(vecs[i].addr, vecs[i].wdata);
         end else begin
            bus_read(vecs[i].addr, rd);
            check($sformatf("vec%0d", i), {480'd0, rd}, {480'd0, vecs[i].exp});
         end
      end

      // --- single frame 0xA5, divider 3 ---
      bus_write(A_DATA, 32'hA5);
      check("a5_idle_before_start", {511'd0, tx}, 512'd1);
      capture(40, wave);
      check("a5_frame", wave, build_wave({1'b0, 1'b1, 8'hA5, 1'b0}, 10, 10, 4, 4));
      read_check("a5_status_after", A_STATUS, 32'h0000_0004);

      // --- FIFO fill, overflow, back-to-back drain ---
      bus_write(A_CTRL, 32'h0);
      for (int i = 0; i < 9; i++) bus_write(A_DATA, 32'h10 + 32'(i));
      read_check("ovf_status_full", A_STATUS, 32'h0000_080A);
      bus_write(A_STATUS, 32'h8);
      read_check("ovf_status_cleared", A_STATUS, 32'h0000_0802);
      bus_write(A_CTRL, 32'h1);
      for (int i = 0; i < 8; i++) begin
         logic [7:0] b;
         b = 8'h10 + 8'(i);
         capture(40, wave);
         check($sformatf("b2b_frame%0d", i), wave, build_wave({1'b0, 1'b1, b, 1'b0}, 10, 10, 4, 4));
      end
      read_check("b2b_status_after", A_STATUS, 32'h0000_0004);

      // --- divider change mid-frame: commits during data bit 1 ---
      bus_write(A_DATA, 32'h55);
      fork
         capture(68, wave);
         begin
            repeat (10) @(negedge clk);
            bus_write(A_BAUD, 32'd7);
         end
      join
      check("div_change_frame", wave, build_wave({1'b0, 1'b1, 8'h55, 1'b0}, 10, 3, 4, 8));
      read_check("div_change_status", A_STATUS, 32'h0000_0004);
      read_check("div_change_baud", A_BAUD, 32'd7);

      // --- reset mid-frame with bytes queued ---
      bus_write(A_BAUD, 32'd3);
      bus_write(A_DATA, 32'h00);
      bus_write(A_DATA, 32'h00);
      bus_write(A_DATA, 32'h00);
      check("mid_tx_low", {511'd0, tx}, 512'd0);
      reset = 1'b1;
      #1;
      check("mid_reset_tx_high", {511'd0, tx}, 512'd1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      read_check("mid_reset_status", A_STATUS, 32'h0000_0004);
      read_check("mid_reset_baud",   A_BAUD,   32'd433);
      read_check("mid_reset_ctrl",   A_CTRL,   32'h1);
      capture(20, wave);
      check("mid_reset_line_idle", wave, {492'd0, 20'hFFFFF});

      // --- parity (or its absence) ---
      bus_write(A_BAUD, 32'd3);
      bus_write(A_CTRL, 32'h3);
      read_check("parity_ctrl_readback", A_CTRL, CTRL_MASK);
      bus_write(A_DATA, 32'h07);
`ifdef RAIFES_UART_PARITY_EN
      capture(44, wave);
      check("parity_frame", wave, build_wave({1'b1, 1'b1, 8'h07, 1'b0}, 11, 11, 4, 4));
`else
      capture(40, wave);
      check("no_parity_frame", wave, build_wave({1'b0, 1'b1, 8'h07, 1'b0}, 10, 10, 4, 4));
`endif
      read_check("parity_status_after", A_STATUS, 32'h0000_0004);
      check("final_hready", {511'd0, bus.hready}, 512'd1);
      check("final_hresp",  {511'd0, bus.hresp},  512'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
